byte_word_packer: RTL and testbench



---
 rtl/byte_word_packer_if.sv | 31 +++
 rtl/byte_word_packer.sv | 99 +++++++++
 tb/tb_byte_word_packer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_word_packer_if.sv
// Stream bundle for byte_word_packer: a byte-wide valid/ready input stream and a
// word-wide valid/ready output stream.
//   slave  : the packer (consumes in_*, produces out_*)
//   master : the environment (produces in_*, consumes out_*)
// Signals: in_data/in_valid/in_last/in_ready, out_data/out_valid/out_ready/
//          out_bytes/out_last.
interface byte_word_packer_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned CNT_W = 4
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_bytes;
  logic             out_last;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_bytes, out_last
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_bytes, out_last
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a byte stream into OUT_W-bit words, little-endian (first byte -> bits
// [IN_W-1:0]). A word closes when all lanes are filled or on in_last, and is
// presented in a single output holding slot.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : byte_word_packer_if.slave (input byte stream, output word stream)
module byte_word_packer #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned CNT_W = 4
) (
  input logic               clk,
  input logic               reset,
  byte_word_packer_if.slave bus
);

  localparam int unsigned Lanes = OUT_W / IN_W;
  localparam int unsigned IdxW  = $clog2(Lanes);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [IdxW-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_bytes_q, out_bytes_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic             close_word;
  logic             xfer;
  logic [OUT_W-1:0] merged;

  // Conservative: a full, non-draining slot blocks every byte, even ones that
  // would not close a word. Never depends on in_valid/in_last.
  assign in_ready   = reset & (~out_valid_q | bus.out_ready);
  assign accept     = bus.in_valid & in_ready;
  assign close_word = accept & ((cnt_q == IdxW'(Lanes - 1)) | bus.in_last);
  assign xfer       = out_valid_q & bus.out_ready;

  // Accumulator with the incoming byte placed in lane cnt_q.
  always_comb begin
    merged = acc_q;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (cnt_q == IdxW'(i)) merged[i*IN_W +: IN_W] = bus.in_data;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (xfer) out_valid_d = 1'b0;

    // A closing word overrides the drain above, so the slot stays full.
    if (accept) begin
      if (close_word) begin
        out_data_d  = merged;
        out_bytes_d = CNT_W'(cnt_q) + CNT_W'(1);
        out_last_d  = bus.in_last;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_bytes = out_bytes_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer: a queue-based reference model is
// compared against the DUT every falling edge, plus literal checks on the
// directed scenarios.
module tb_byte_word_packer;

  localparam int unsigned N = 8;

  logic clk;
  logic reset;

  byte_word_packer_if #(.IN_W(8), .OUT_W(64), .CNT_W(4)) bif ();

  byte_word_packer #(.IN_W(8), .OUT_W(64), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the open word in a queue, plus one output slot.
  logic [7:0]  part[$];
  bit          m_valid;
  logic [63:0] m_data;
  int          m_bytes;
  bit          m_last;
  bit          m_rdy, m_take;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      part.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_bytes = 0;
      m_last  = 1'b0;
    end else begin
      m_rdy  = !m_valid || bif.out_ready;
      m_take = bif.in_valid && m_rdy;
      if (m_valid && bif.out_ready) m_valid = 1'b0;
      if (m_take) begin
        part.push_back(bif.in_data);
        if (part.size() == N || bif.in_last) begin
          m_data = '0;
          foreach (part[i]) m_data |= 64'(part[i]) << (8 * i);
          m_bytes = part.size();
          m_last  = bif.in_last;
          m_valid = 1'b1;
          part.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("in_ready", 64'(bif.in_ready), 64'(reset && (!m_valid || bif.out_ready)));
    chk("out_valid", 64'(bif.out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", bif.out_data, m_data);
      chk("out_bytes", 64'(bif.out_bytes), 64'(m_bytes));
      chk("out_last", 64'(bif.out_last), 64'(m_last));
    end
  end

  // Called at posedge+1; holds the byte until accepted (bounded).
  task automatic send(input logic [7:0] b, input logic last);
    int  n = 0;
    bit  done = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    bif.in_last  = last;
    while (!done && n < 50) begin
      done = bif.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", 64'(done), 64'(1));
  endtask

  task automatic idle(input int cycles);
    bif.in_valid = 1'b0;
    bif.in_last  = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      bif.in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input string name, input logic [63:0] d, input int nb,
                             input logic last);
    chk({name, "_valid"}, 64'(bif.out_valid), 64'(1));
    chk({name, "_data"}, bif.out_data, d);
    chk({name, "_bytes"}, 64'(bif.out_bytes), 64'(nb));
    chk({name, "_last"}, 64'(bif.out_last), 64'(last));
  endtask

  task automatic expect_cleared(input string name);
    chk({name, "_valid"}, 64'(bif.out_valid), 64'(0));
    chk({name, "_data"}, bif.out_data, 64'(0));
    chk({name, "_bytes"}, 64'(bif.out_bytes), 64'(0));
    chk({name, "_last"}, 64'(bif.out_last), 64'(0));
    chk({name, "_in_ready"}, 64'(bif.in_ready), 64'(0));
  endtask

  initial begin
    reset         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.in_last   = 1'b0;
    bif.out_ready = 1'b1;
    #1;
    expect_cleared("rst");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Full word 0x01..0x08.
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    expect_word("w8", 64'h0807060504030201, 8, 1'b0);
    idle(2);

    // Partial word flushed by in_last.
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    expect_word("w3", 64'h0000000000CCBBAA, 3, 1'b1);
    idle(2);

    // Backpressure: hold the word for 5 cycles with a pending byte offered.
    bif.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), 1'b0);
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h99;
    bif.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_in_ready", 64'(bif.in_ready), 64'(0));
      expect_word("hold", 64'h3837363534333231, 8, 1'b0);
      @(posedge clk);
      #1;
    end
    bif.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(bif.in_ready), 64'(1));
    @(posedge clk);
    #1;
    // The held byte was accepted on the draining edge, into lane 0.
    expect_word("after_hold", 64'h0000000000000099, 1, 1'b1);
    idle(2);

    // 16 back-to-back bytes: two words, 8 cycles apart.
    for (int i = 0; i < 16; i++) begin
      send(8'h10 + 8'(i), 1'b0);
      if (i == 7) expect_word("b2b0", 64'h1716151413121110, 8, 1'b0);
      if (i == 15) expect_word("b2b1", 64'h1F1E1D1C1B1A1918, 8, 1'b0);
    end
    idle(2);

    // Reset mid-word, not aligned to the clock.
    for (int i = 0; i < 5; i++) send(8'h41 + 8'(i), 1'b0);
    bif.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    expect_cleared("midrst");
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(8'h21 + 8'(i), 1'b0);
    expect_word("postrst", 64'h2827262524232221, 8, 1'b0);
    idle(2);

    // Single byte with in_last.
    send(8'h5A, 1'b1);
    expect_word("single", 64'h000000000000005A, 1, 1'b1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
